// File: rtl/my_sram.sv
// Single-clock FIFO over a register-file SRAM with a registered read port.
// Optional macro MY_SRAM_OVF_STICKY_EN: overflow latches until reset instead of pulsing.
module my_sram #(
    parameter int BITS       = 12,
    parameter int word_depth = 8,
    parameter int addr_width = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            read,
    input  logic            write,
    input  logic [BITS-1:0] data_in,
    output logic [BITS-1:0] data_out,
    output logic            ready,
    output logic            overflow
);

    localparam logic [addr_width:0] FULL_CNT = word_depth[addr_width:0];

    logic [BITS-1:0]       mem [word_depth];
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   count;
    logic                  full;
    logic                  empty;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  drop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign rd_acc = read & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_acc = write & (~full | rd_acc);
    assign drop   = write & full & ~rd_acc;
    assign ready  = ~empty;

    // Storage is never cleared; only the reset-gated write enable touches it.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + addr_width'(1);
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + addr_width'(1);
                data_out <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (addr_width+1)'(1);
                2'b01:   count <= count - (addr_width+1)'(1);
                default: count <= count;
            endcase
`ifdef MY_SRAM_OVF_STICKY_EN
            overflow <= overflow | drop;
`else
            overflow <= drop;
`endif
        end
    end

endmodule

// File: tb/tb_my_sram.sv
// Randomized scoreboard bench for my_sram against a queue-based FIFO model.
module tb_my_sram;

    localparam int BITS = 12;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            read = 1'b0;
    logic            write = 1'b0;
    logic [BITS-1:0] data_in = '0;
    logic [BITS-1:0] data_out;
    logic            ready;
    logic            overflow;

    typedef struct {
        logic [BITS-1:0] d;
        logic            rdy;
        logic            ovf;
        string           tag;
    } exp_t;

    exp_t            exp_q[$];
    logic [BITS-1:0] fifo_q[$];
    logic [BITS-1:0] m_dout = '0;
    logic            m_ovf = 1'b0;
    int              total = 0;
    int              bad = 0;

    my_sram #(.BITS(BITS), .word_depth(DEPTH), .addr_width(3)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write),
        .data_in(data_in), .data_out(data_out), .ready(ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered state that the model predicted.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".data_out"}, data_out, e.d);
            chk({e.tag, ".ready"}, {11'd0, ready}, {11'd0, e.rdy});
            chk({e.tag, ".overflow"}, {11'd0, overflow}, {11'd0, e.ovf});
        end
    end

    // One clock: drive inputs, let the edge happen, advance the model, queue expectation.
    task automatic step(input logic rs, input logic r, input logic w,
                        input logic [BITS-1:0] d, input string tag);
        logic rd_ok, full, drop;
        exp_t e;
        rst_n = rs; read = r; write = w; data_in = d;
        @(posedge clk);
        if (!rs) begin
            fifo_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
        end else begin
            rd_ok = r && (fifo_q.size() > 0);
            full  = (fifo_q.size() == DEPTH);
            drop  = w && full && !rd_ok;
            if (rd_ok) m_dout = fifo_q.pop_front();
            if (w && !drop) fifo_q.push_back(d);
`ifdef MY_SRAM_OVF_STICKY_EN
            m_ovf = m_ovf | drop;
`else
            m_ovf = drop;
`endif
        end
        e.d = m_dout; e.rdy = (fifo_q.size() != 0); e.ovf = m_ovf; e.tag = tag;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        logic [BITS-1:0] w0;
        step(0, 0, 0, '0, "reset");
        step(0, 1, 1, 12'hABC, "reset_ovr");
        step(1, 0, 0, '0, "idle");
        step(1, 1, 0, '0, "rd_empty");
        for (int i = 0; i < 8; i++)
            step(1, 0, 1, (i == 0) ? 12'h0E0 : BITS'(i), "fill");
        step(1, 0, 1, 12'h008, "drop");
        step(1, 0, 0, '0, "after_drop");
        for (int i = 0; i < 9; i++)
            step(1, 1, 0, '0, "drain");
        for (int i = 0; i < 8; i++)
            step(1, 0, 1, (i == 0) ? 12'h0E0 : BITS'(i), "refill");
        for (int i = 0; i < 14; i++)
            step(1, 1, 1, BITS'(12'h010 + i), "rw_full");
        for (int i = 0; i < 10; i++)
            step(1, 1, 0, '0, "drain2");
        for (int i = 0; i < 4; i++)
            step(1, 0, 1, BITS'(12'h100 + i), "half");
        step(0, 0, 0, '0, "mid_reset");
        step(1, 0, 1, 12'h5A5, "post_wr");
        step(1, 1, 0, '0, "post_rd");
        // Random phases alternate between write-heavy and read-heavy traffic.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = ((i / 40) % 2 == 0) ? 75 : 30;
            w0 = BITS'($urandom);
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 100 - wp) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0, w0, "rand");
        end
        step(1, 0, 0, '0, "tail");
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
